// File: rtl/score_keeper.sv
// ----------------------------------------------------------------------------
// score_keeper
//   Match scoring and serve sequencing for Pong. Counts goals for P1 and P2,
//   paces the serve delay in frames and declares the match winner. Feeds the
//   thermometer pip inputs of the score display and the freeze/serve controls
//   of the ball stage.
//
// Parameters
//   MAX_POINTS          points needed to win (1..7)
//   SERVE_DELAY_FRAMES  frame_tick pulses spent waiting before a serve (>= 1)
//
// Ports
//   clk          pixel clock, all state on its rising edge
//   rst_n        asynchronous active-low reset
//   frame_tick   one-clk pulse per frame
//   goal_p1      level, P1 scores (only its rising edge acts)
//   goal_p2      level, P2 scores (only its rising edge acts)
//   start_btn    level, start / new-match request (rising edge acts)
//   score_p1/2   current points, 0..MAX_POINTS
//   pips_p1/2    thermometer of the scores, bit i = (score > i)
//   ball_freeze  1 = ball held at centre
//   serve        one-clk launch pulse
//   serve_dir    0 = serve toward P1, 1 = serve toward P2
//   game_over    1 while the match is decided
//   winner       00 none, 01 P1, 10 P2; held until the next match starts
// ----------------------------------------------------------------------------
module score_keeper #(
    parameter int unsigned MAX_POINTS         = 5,
    parameter int unsigned SERVE_DELAY_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       start_btn,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic [4:0] pips_p1,
    output logic [4:0] pips_p2,
    output logic       ball_freeze,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned CntW = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SERVE_DELAY_FRAMES - 1);
    localparam logic [2:0] MaxScore = 3'(MAX_POINTS);

    typedef enum logic [1:0] {
        StIdle,
        StServeWait,
        StPlay,
        StGameOver
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      score_p1_q, score_p1_d;
    logic [2:0]      score_p2_q, score_p2_d;
    logic [1:0]      winner_q, winner_d;
    logic            serve_dir_q, serve_dir_d;
    logic            serve_q, serve_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Edge-detect history; reset to 1 so a level already high at reset
    // release is not mistaken for a fresh edge.
    logic goal_p1_q, goal_p2_q, start_q;
    logic rise_p1, rise_p2, rise_start;

    logic [2:0] p1_inc, p2_inc;

    assign rise_p1    = goal_p1 & ~goal_p1_q;
    assign rise_p2    = goal_p2 & ~goal_p2_q;
    assign rise_start = start_btn & ~start_q;

    // Saturating increments; the FSM leaves PLAY on reaching MaxScore, the
    // clamp only guards against ever wrapping.
    assign p1_inc = (score_p1_q < MaxScore) ? score_p1_q + 3'd1 : score_p1_q;
    assign p2_inc = (score_p2_q < MaxScore) ? score_p2_q + 3'd1 : score_p2_q;

    always_comb begin
        state_d     = state_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        serve_d     = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle, StGameOver: begin
                if (rise_start) begin
                    state_d    = StServeWait;
                    score_p1_d = 3'd0;
                    score_p2_d = 3'd0;
                    winner_d   = 2'b00;
                    cnt_d      = '0;
                end
            end

            StServeWait: begin
                // Goal and start edges are deliberately ignored while waiting.
                if (frame_tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = StPlay;
                        serve_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            StPlay: begin
                // Counter is idle here; holding it at zero also gives a goal
                // priority over a coincident frame_tick.
                cnt_d = '0;
                if (rise_p1 && rise_p2) begin
                    // Simultaneous goals: point is replayed, nobody scores.
                    state_d = StServeWait;
                end else if (rise_p1) begin
                    score_p1_d  = p1_inc;
                    serve_dir_d = 1'b1;  // serve toward the conceding player (P2)
                    if (p1_inc == MaxScore) begin
                        state_d  = StGameOver;
                        winner_d = 2'b01;
                    end else begin
                        state_d = StServeWait;
                    end
                end else if (rise_p2) begin
                    score_p2_d  = p2_inc;
                    serve_dir_d = 1'b0;  // serve toward P1
                    if (p2_inc == MaxScore) begin
                        state_d  = StGameOver;
                        winner_d = 2'b10;
                    end else begin
                        state_d = StServeWait;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            score_p1_q  <= 3'd0;
            score_p2_q  <= 3'd0;
            winner_q    <= 2'b00;
            serve_dir_q <= 1'b0;
            serve_q     <= 1'b0;
            cnt_q       <= '0;
            goal_p1_q   <= 1'b1;
            goal_p2_q   <= 1'b1;
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            serve_q     <= serve_d;
            cnt_q       <= cnt_d;
            goal_p1_q   <= goal_p1;
            goal_p2_q   <= goal_p2;
            start_q     <= start_btn;
        end
    end

    // Pips decode straight from the score registers so they move on the same
    // edge as the score; bits at or above MAX_POINTS are forced low.
    always_comb begin
        pips_p1 = 5'b00000;
        pips_p2 = 5'b00000;
        for (int unsigned i = 0; i < 5; i++) begin
            pips_p1[i] = (i < MAX_POINTS) && (score_p1_q > 3'(i));
            pips_p2[i] = (i < MAX_POINTS) && (score_p2_q > 3'(i));
        end
    end

    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign winner      = winner_q;
    assign serve_dir   = serve_dir_q;
    assign serve       = serve_q;
    assign ball_freeze = (state_q != StPlay);
    assign game_over   = (state_q == StGameOver);

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    localparam int MP  = 5;
    localparam int SDF = 3;

    localparam int MIdle = 0, MWait = 1, MPlay = 2, MOver = 3;
    localparam int EvServe = 0, EvScore = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, goal_p1, goal_p2, start_btn;
    logic [2:0] score_p1, score_p2;
    logic [4:0] pips_p1, pips_p2;
    logic       ball_freeze, serve, serve_dir, game_over;
    logic [1:0] winner;

    score_keeper #(
        .MAX_POINTS        (MP),
        .SERVE_DELAY_FRAMES(SDF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .goal_p1    (goal_p1),
        .goal_p2    (goal_p2),
        .start_btn  (start_btn),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .pips_p1    (pips_p1),
        .pips_p2    (pips_p2),
        .ball_freeze(ball_freeze),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int s1;
        int s2;
        int win;
        int dir;
        int gover;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model: match state in plain integers.
    int m_mode, m_ticks, m_s1, m_s2, m_win, m_dir;
    bit m_p1, m_p2, m_ps;
    int fcnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int therm(input int s);
        int r = 0;
        for (int i = 0; i < 5; i++)
            if (s > i && i < MP) r |= (1 << i);
        return r;
    endfunction

    function automatic bit tk();
        fcnt = (fcnt + 1) % 10;
        return (fcnt == 0);
    endfunction

    task automatic model_reset();
        m_mode = MIdle; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
        m_p1 = 1'b1; m_p2 = 1'b1; m_ps = 1'b1;
        exp_q.delete();
    endtask

    // Apply inputs for the next rising edge, predict its effect, then advance.
    task automatic step(input bit fr, input bit g1, input bit g2, input bit st);
        bit r1, r2, rs;
        int o1, o2, ow;
        frame_tick = fr; goal_p1 = g1; goal_p2 = g2; start_btn = st;
        r1 = g1 && !m_p1; r2 = g2 && !m_p2; rs = st && !m_ps;
        m_p1 = g1; m_p2 = g2; m_ps = st;
        o1 = m_s1; o2 = m_s2; ow = m_win;
        case (m_mode)
            MIdle, MOver: if (rs) begin
                m_mode = MWait; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0;
            end
            MWait: if (fr) begin
                if (m_ticks == SDF - 1) begin
                    m_mode = MPlay; m_ticks = 0;
                    exp_q.push_back('{EvServe, cyc + 1, m_s1, m_s2, m_win, m_dir, 0});
                end else begin
                    m_ticks++;
                end
            end
            default: begin
                m_ticks = 0;
                if (r1 && r2) m_mode = MWait;
                else if (r1) begin
                    m_s1++; m_dir = 1;
                    if (m_s1 == MP) begin m_mode = MOver; m_win = 1; end
                    else m_mode = MWait;
                end else if (r2) begin
                    m_s2++; m_dir = 0;
                    if (m_s2 == MP) begin m_mode = MOver; m_win = 2; end
                    else m_mode = MWait;
                end
            end
        endcase
        if (o1 != m_s1 || o2 != m_s2 || ow != m_win)
            exp_q.push_back('{EvScore, cyc + 1, m_s1, m_s2, m_win, m_dir,
                              (m_mode == MOver) ? 1 : 0});
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_score_p1"}, int'(score_p1), 0);
        chk({tag, "_score_p2"}, int'(score_p2), 0);
        chk({tag, "_pips"}, int'({pips_p1, pips_p2}), 0);
        chk({tag, "_freeze"}, int'(ball_freeze), 1);
        chk({tag, "_serve"}, int'(serve), 0);
        chk({tag, "_dir"}, int'(serve_dir), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
        chk({tag, "_winner"}, int'(winner), 0);
    endtask

    task automatic do_reset(input string tag, input int hold);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals(tag);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_play(input int budget, input bit g1, input bit g2);
        for (int i = 0; i < budget; i++) begin
            if (m_mode == MPlay) return;
            step(tk(), g1, g2, 1'b0);
        end
        chk("wait_play_timeout", m_mode, MPlay);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk(kind == EvServe ? "unexpected_serve" : "unexpected_score_change", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("ev_serve_dir", int'(serve_dir), e.dir);
        if (kind == EvServe) begin
            chk("serve_freeze", int'(ball_freeze), 0);
        end else begin
            chk("ev_score_p1", int'(score_p1), e.s1);
            chk("ev_score_p2", int'(score_p2), e.s2);
            chk("ev_pips_p1", int'(pips_p1), therm(e.s1));
            chk("ev_pips_p2", int'(pips_p2), therm(e.s2));
            chk("ev_winner", int'(winner), e.win);
            chk("ev_game_over", int'(game_over), e.gover);
            chk("ev_freeze", int'(ball_freeze), 1);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue.
    initial begin : monitor
        logic [2:0] pt1, pt2;
        logic [1:0] pw;
        pt1 = 0; pt2 = 0; pw = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pt1 = 0; pt2 = 0; pw = 0;
            end else begin
                if (serve) check_ev(EvServe);
                if (score_p1 != pt1 || score_p2 != pt2 || winner != pw) check_ev(EvScore);
                pt1 = score_p1; pt2 = score_p2; pw = winner;
            end
        end
    end

    initial begin : driver
        bit r1, r2, rs;
        bit seen;
        rst_n = 1'b0; frame_tick = 1'b0; goal_p1 = 1'b1; goal_p2 = 1'b0; start_btn = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // Levels high through reset release are not edges.
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (20) step(tk(), 1'b1, 1'b0, 1'b1);
        chk("idle_freeze", int'(ball_freeze), 1);
        chk("idle_score_p1", int'(score_p1), 0);

        // Start, then serve after the third tick.
        step(tk(), 1'b0, 1'b0, 1'b0);
        step(tk(), 1'b0, 1'b0, 1'b1);
        wait_play(100, 1'b0, 1'b0);

        // Goal held high for 50 clocks counts once.
        repeat (50) step(tk(), 1'b1, 1'b0, 1'b0);
        chk("held_score_p1", int'(score_p1), 1);
        chk("held_pips_p1", int'(pips_p1), 1);
        chk("held_dir", int'(serve_dir), 1);
        step(tk(), 1'b0, 1'b0, 1'b0);

        // Simultaneous goals: replay.
        wait_play(100, 1'b0, 1'b0);
        step(tk(), 1'b1, 1'b1, 1'b0);
        chk("both_score_p1", int'(score_p1), 1);
        chk("both_score_p2", int'(score_p2), 0);
        chk("both_freeze", int'(ball_freeze), 1);
        step(tk(), 1'b0, 1'b0, 1'b0);
        wait_play(100, 1'b0, 1'b0);

        // P2 runs to MAX_POINTS.
        for (int i = 0; i < MP; i++) begin
            wait_play(100, 1'b0, 1'b0);
            step(tk(), 1'b0, 1'b1, 1'b0);
            step(tk(), 1'b0, 1'b0, 1'b0);
        end
        chk("win_pips_p2", int'(pips_p2), 5'b11111);
        chk("win_winner", int'(winner), 2);
        chk("win_game_over", int'(game_over), 1);
        for (int i = 0; i < 30; i++) step(tk(), 1'(i % 3 == 0), 1'(i % 4 == 1), 1'b0);
        chk("over_score_p2", int'(score_p2), MP);
        step(tk(), 1'b0, 1'b0, 1'b1);
        chk("restart_score_p2", int'(score_p2), 0);
        chk("restart_winner", int'(winner), 0);
        chk("restart_game_over", int'(game_over), 0);
        step(tk(), 1'b0, 1'b0, 1'b0);

        // Reset mid-match at 3-2 while waiting to serve.
        for (int i = 0; i < 5; i++) begin
            wait_play(100, 1'b0, 1'b0);
            step(tk(), 1'(i % 2 == 0), 1'(i % 2 == 1), 1'b0);
            step(tk(), 1'b0, 1'b0, 1'b0);
        end
        chk("pre_reset_score_p1", int'(score_p1), 3);
        chk("pre_reset_score_p2", int'(score_p2), 2);
        do_reset("midmatch", 2);
        for (int i = 0; i < 100; i++) step(tk(), 1'(i % 7 < 3), 1'(i % 5 < 2), 1'b0);
        chk("after_reset_freeze", int'(ball_freeze), 1);

        // Reset landing while serve is high.
        step(tk(), 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (serve) seen = 1'b1;
            else step(tk(), 1'b0, 1'b0, 1'b0);
        end
        chk("serve_seen", int'(seen), 1);
        do_reset("during_serve", 2);

        // Randomised play.
        r1 = 0; r2 = 0; rs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) r1 = ~r1;
            if ($urandom_range(0, 11) == 0) r2 = ~r2;
            if ($urandom_range(0, 39) == 0) rs = ~rs;
            if ($urandom_range(0, 1499) == 0) do_reset("rand", 1 + $urandom_range(0, 2));
            step(1'($urandom_range(0, 5) == 0), r1, r2, rs);
        end
        repeat (3) step(1'b0, r1, r2, rs);
        chk("leftover_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
